// File: rtl/led_pattern_sequencer.sv
// Segment-table LED pattern player: plays (level, duration) entries in order,
// once or looped, with a tick prescaler and single-cycle done pulse.
module led_pattern_sequencer #(
    parameter int NUM_SEG = 8,
    parameter int DUR_W   = 8,
    parameter int PRESC   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_SEG)-1:0] cfg_addr,
    input  logic                       cfg_level,
    input  logic [DUR_W-1:0]           cfg_dur,
    input  logic [$clog2(NUM_SEG):0]   seg_count,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
    output logic                       led,
    output logic                       busy,
    output logic [$clog2(NUM_SEG)-1:0] seg_idx,
    output logic                       done
);

    localparam int AW    = $clog2(NUM_SEG);
    localparam int PW    = $clog2(PRESC) + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   NUM_SEG_L  = (AW+1)'(NUM_SEG);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [AW:0]       len_r, len_s;
    logic [AW-1:0]     seg_idx_r, seg_idx_s;
    logic              led_r, led_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [PW-1:0]     presc_r, presc_s;
    logic [DUR_W-1:0]  tmr_r, tmr_s;

    // Table is sized to the full address space so any index is in range.
    logic              level_r [DEPTH];
    logic [DUR_W-1:0]  dur_r   [DEPTH];

    logic              tick_s;
    logic              seg_end_s;
    logic              last_s;
    logic              start_ok_s;
    logic [AW-1:0]     idx_inc_s;
    logic [DUR_W-1:0]  cur_dur_s;

    assign cur_dur_s  = dur_r[seg_idx_r];
    assign idx_inc_s  = seg_idx_r + AW'(1);
    assign tick_s     = (presc_r == PRESC_LAST);
    assign seg_end_s  = (cur_dur_s == {DUR_W{1'b0}}) || (tmr_r == (cur_dur_s - DUR_W'(1)));
    assign last_s     = ({1'b0, seg_idx_r} == (len_r - (AW+1)'(1)));
    assign start_ok_s = start && !stop && (seg_count != {(AW+1){1'b0}}) && (seg_count <= NUM_SEG_L);

    // Segment table storage; writes only while idle and only to real entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                level_r[i] <= 1'b0;
                dur_r[i]   <= {DUR_W{1'b0}};
            end
        end else if (cfg_we && (state_r == ST_IDLE) && ({1'b0, cfg_addr} < NUM_SEG_L)) begin
            level_r[cfg_addr] <= cfg_level;
            dur_r[cfg_addr]   <= cfg_dur;
        end
    end

    // Playback state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            len_r     <= {(AW+1){1'b0}};
            seg_idx_r <= {AW{1'b0}};
            led_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            presc_r   <= {PW{1'b0}};
            tmr_r     <= {DUR_W{1'b0}};
        end else begin
            state_r   <= state_s;
            len_r     <= len_s;
            seg_idx_r <= seg_idx_s;
            led_r     <= led_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            presc_r   <= presc_s;
            tmr_r     <= tmr_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        len_s     = len_r;
        seg_idx_s = seg_idx_r;
        led_s     = led_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        presc_s   = presc_r;
        tmr_s     = tmr_r;
        case (state_r)
            ST_IDLE: begin
                led_s     = 1'b0;
                busy_s    = 1'b0;
                seg_idx_s = {AW{1'b0}};
                presc_s   = {PW{1'b0}};
                tmr_s     = {DUR_W{1'b0}};
                if (start_ok_s) begin
                    state_s = ST_RUN;
                    len_s   = seg_count;
                    busy_s  = 1'b1;
                    led_s   = level_r[0];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s   = ST_IDLE;
                    led_s     = 1'b0;
                    busy_s    = 1'b0;
                    seg_idx_s = {AW{1'b0}};
                    presc_s   = {PW{1'b0}};
                    tmr_s     = {DUR_W{1'b0}};
                end else if (tick_s) begin
                    presc_s = {PW{1'b0}};
                    if (seg_end_s) begin
                        tmr_s = {DUR_W{1'b0}};
                        if (!last_s) begin
                            seg_idx_s = idx_inc_s;
                            led_s     = level_r[idx_inc_s];
                        end else if (loop_en) begin
                            seg_idx_s = {AW{1'b0}};
                            led_s     = level_r[0];
                        end else begin
                            state_s   = ST_IDLE;
                            seg_idx_s = {AW{1'b0}};
                            led_s     = 1'b0;
                            busy_s    = 1'b0;
                            done_s    = 1'b1;
                        end
                    end else begin
                        tmr_s = tmr_r + DUR_W'(1);
                    end
                end else begin
                    presc_s = presc_r + PW'(1);
                end
            end
            default: begin
                state_s   = ST_IDLE;
                led_s     = 1'b0;
                busy_s    = 1'b0;
                seg_idx_s = {AW{1'b0}};
            end
        endcase
    end

    assign led     = led_r;
    assign busy    = busy_r;
    assign seg_idx = seg_idx_r;
    assign done    = done_r;

endmodule
